cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 33 +++
 rtl/cdb_arbiter.sv | 55 +++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter handshake bundle: four
// producer request lanes in, one-hot grant and CDB broadcast out.
interface cdb_arbiter_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
);
  logic [3:0]          req_valid;
  logic [4*TAG_W-1:0]  req_tag;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_branch;
  logic [3:0]          req_branch_taken;
  logic                flush;
  logic [3:0]          grant;
  logic                CDB_valid;
  logic [TAG_W-1:0]    CDB_tag;
  logic [DATA_W-1:0]   CDB_data;
  logic                CDB_branch;
  logic                CDB_branch_taken;

  modport master (
    output req_valid, req_tag, req_data,
    output req_branch, req_branch_taken, flush,
    input  grant, CDB_valid, CDB_tag, CDB_data,
    input  CDB_branch, CDB_branch_taken
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    input  req_branch, req_branch_taken, flush,
    output grant, CDB_valid, CDB_tag, CDB_data,
    output CDB_branch, CDB_branch_taken
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for four execution units onto a
// single registered common data bus.
module cdb_arbiter #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         reset,
  cdb_arbiter_if.slave bus
);

  logic [1:0] rr_ptr;
  logic [1:0] g_idx;
  logic       g_any;
  logic [1:0] idx;

  // Scan from rr_ptr upward; first requester wins.
  always_comb begin
    bus.grant = 4'b0000;
    g_idx     = 2'd0;
    g_any     = 1'b0;
    idx       = 2'd0;
    if (!reset && !bus.flush) begin
      for (int k = 0; k < 4; k++) begin
        idx = rr_ptr + 2'(k);
        if (!g_any && bus.req_valid[idx]) begin
          g_any          = 1'b1;
          g_idx          = idx;
          bus.grant[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr               <= 2'd0;
      bus.CDB_valid        <= 1'b0;
      bus.CDB_tag          <= '0;
      bus.CDB_data         <= '0;
      bus.CDB_branch       <= 1'b0;
      bus.CDB_branch_taken <= 1'b0;
    end else begin
      bus.CDB_valid <= g_any;
      if (g_any) begin
        rr_ptr               <= g_idx + 2'd1;
        bus.CDB_tag          <= bus.req_tag[g_idx*TAG_W +: TAG_W];
        bus.CDB_data         <= bus.req_data[g_idx*DATA_W +: DATA_W];
        bus.CDB_branch       <= bus.req_branch[g_idx];
        bus.CDB_branch_taken <= bus.req_branch_taken[g_idx];
      end
    end
  end

endmodule
